// File: rtl/instr_pkg.sv
// Shared instruction-set constants: mnemonic codes, MIPS opcode/funct fields and
// loader FSM states, common to the control-unit decoder and the program loader.
package instr_pkg;

  typedef enum logic [4:0] {
    M_ADD  = 5'd0,  M_SUB  = 5'd1,  M_AND  = 5'd2,  M_OR   = 5'd3,
    M_NOR  = 5'd4,  M_SLT  = 5'd5,  M_XOR  = 5'd6,  M_ADDI = 5'd7,
    M_LW   = 5'd8,  M_SW   = 5'd9,  M_BEQ  = 5'd10, M_BNE  = 5'd11,
    M_ANDI = 5'd12, M_ORI  = 5'd13, M_XORI = 5'd14, M_J    = 5'd15
  } mnem_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_FULL} ldr_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Combinational MIPS encoder: mnemonic code plus operand fields -> 32-bit word.
// Codes outside the supported set raise illegal_o and produce an all-zero word.
module instr_encoder
  import instr_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, rs_i, rt_i, imm_i};
  endfunction

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (mnem_i)
      M_ADD:   word_o = rtype(FN_ADD);
      M_SUB:   word_o = rtype(FN_SUB);
      M_AND:   word_o = rtype(FN_AND);
      M_OR:    word_o = rtype(FN_OR);
      M_NOR:   word_o = rtype(FN_NOR);
      M_SLT:   word_o = rtype(FN_SLT);
      M_XOR:   word_o = rtype(FN_XOR);
      M_ADDI:  word_o = itype(OP_ADDI);
      M_LW:    word_o = itype(OP_LW);
      M_SW:    word_o = itype(OP_SW);
      M_BEQ:   word_o = itype(OP_BEQ);
      M_BNE:   word_o = itype(OP_BNE);
      M_ANDI:  word_o = itype(OP_ANDI);
      M_ORI:   word_o = itype(OP_ORI);
      M_XORI:  word_o = itype(OP_XORI);
      M_J:     word_o = {OP_J, target_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction commands, encodes them and writes them
// sequentially into instruction memory. INSTR_LOADER_CHECKSUM_EN adds an XOR checksum port.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_mnem,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
`ifdef INSTR_LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;

  ldr_state_t        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              rdy_q, we_q, full_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        mnem_q, rs_q, rt_q, rd_q;
  logic [15:0]       imm_q;
  logic [25:0]       target_q;
  logic [31:0]       word_d;
  logic              illegal_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]       checksum_q;
`endif

  instr_encoder u_enc (
    .mnem_i    (mnem_q),
    .rs_i      (rs_q),
    .rt_i      (rt_q),
    .rd_i      (rd_q),
    .imm_i     (imm_q),
    .target_i  (target_q),
    .word_o    (word_d),
    .illegal_o (illegal_d)
  );

  // clear shares the reset path so a command in flight is dropped unwritten
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= S_IDLE;
      ptr_q      <= BASE;
      count_q    <= '0;
      rdy_q      <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && rdy_q) begin
            mnem_q   <= cmd_mnem;
            rs_q     <= cmd_rs;
            rt_q     <= cmd_rt;
            rd_q     <= cmd_rd;
            imm_q    <= cmd_imm;
            target_q <= cmd_target;
            rdy_q    <= 1'b0;
            state_q  <= S_ENC;
          end
        end
        S_ENC: begin
          if (illegal_d) begin
            err_q   <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wdata_q <= word_d;
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            state_q <= S_WR;
          end
        end
        S_WR: begin
          count_q <= count_q + (ADDR_W+1)'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
          checksum_q <= checksum_q ^ wdata_q;
`endif
          // The last word parks the pointer instead of wrapping onto address 0
          if (ptr_q == LAST) begin
            full_q  <= 1'b1;
            state_q <= S_FULL;
          end else begin
            ptr_q   <= ptr_q + ADDR_W'(1);
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_FULL;
      endcase
    end
  end

  assign cmd_ready  = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (4-word memory so the full condition is reachable);
// checks the checksum port when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instr_encoder_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, clear, cmd_valid;
  logic [4:0]    cmd_mnem, cmd_rs, cmd_rt, cmd_rd;
  logic [15:0]   cmd_imm;
  logic [25:0]   cmd_target;
  logic          cmd_ready, imem_we, full, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mnem(cmd_mnem), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count),
`ifdef INSTR_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Write log and error-pulse counter, sampled mid-cycle
  logic [AW-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];
  int            err_pulses = 0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
    if (err === 1'b1) err_pulses++;
  end

  // Reference encoding from the instruction tables; bit 32 flags an illegal code
  function automatic logic [32:0] ref_enc(input int m, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [15:0] imm,
                                          input logic [25:0] tgt);
    int functs[7] = '{32, 34, 36, 37, 39, 42, 38};
    int ops[8]    = '{8, 35, 43, 4, 5, 12, 13, 14};
    if (m < 7)       return {1'b0, 6'd0, rs, rt, rd, 5'd0, 6'(functs[m])};
    else if (m < 15) return {1'b0, 6'(ops[m-7]), rs, rt, imm};
    else if (m == 15) return {1'b0, 6'd2, tgt};
    else             return {1'b1, 32'd0};
  endfunction

  task automatic set_fields(input int m, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    cmd_mnem = 5'(m); cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm; cmd_target = tgt;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Offer one command, wait (bounded) for acceptance, then let it finish
  task automatic send(input int m, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm, input logic [25:0] tgt);
    bit ok = 1'b0;
    set_fields(m, rs, rt, rd, imm, tgt);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end else begin
      repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; cmd_valid = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== '0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", imem_addr); end
    n_cmp++; if (imem_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", imem_wdata); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", full); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
`ifdef INSTR_LOADER_CHECKSUM_EN
    n_cmp++; if (checksum !== 32'd0) begin n_bad++; $display("FAIL rst_checksum: got %h want 0", checksum); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    set_fields(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    cmd_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", cmd_ready); end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL add_we_early: got %b want 0", imem_we); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL add_busy: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (imem_we !== 1'b1) begin n_bad++; $display("FAIL add_we: got %b want 1", imem_we); end
    n_cmp++; if (imem_addr !== 2'd0) begin n_bad++; $display("FAIL add_addr: got %0d want 0", imem_addr); end
    n_cmp++; if (imem_wdata !== 32'h00221820) begin n_bad++; $display("FAIL add_wdata: got %h want 00221820", imem_wdata); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL add_we_once: got %b want 0", imem_we); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL add_count: got %0d want 1", count); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready_back: got %b want 1", cmd_ready); end
    n_cmp++; if (imem_wdata !== 32'h00221820) begin n_bad++; $display("FAIL add_wdata_hold: got %h want 00221820", imem_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_sequence();
    logic [31:0] exp_w[3] = '{32'h20080005, 32'h8D090004, 32'h08000010};
    int base;
    do_clear();
    base = wq_data.size();
    send(7, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0);
    send(8, 5'd8, 5'd9, 5'd0, 16'd4, 26'd0);
    send(15, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
    n_cmp++;
    if (wq_data.size() != base + 3) begin
      n_bad++; $display("FAIL seq_nwrites: got %0d want 3", wq_data.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (wq_data[base+i] !== exp_w[i] || wq_addr[base+i] !== AW'(i)) begin
          n_bad++;
          $display("FAIL seq_word%0d: got addr %0d data %h want addr %0d data %h",
                   i, wq_addr[base+i], wq_data[base+i], i, exp_w[i]);
        end
      end
    end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL seq_count: got %0d want 3", count); end
  endtask

  task automatic test_illegal();
    int base, e0;
    logic [AW:0] c0;
    do_clear();
    base = wq_data.size();
    send(10, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
    n_cmp++;
    if (wq_data.size() != base + 1 || wq_data[wq_data.size()-1] !== 32'h1022FFFF) begin
      n_bad++; $display("FAIL beq_word: writes %0d, last %h want 1 write of 1022ffff",
                        wq_data.size() - base, wq_data[wq_data.size()-1]);
    end
    base = wq_data.size(); e0 = err_pulses; c0 = count;
    send(20, 5'd3, 5'd4, 5'd5, 16'h1234, 26'h123);
    n_cmp++; if (err_pulses != e0 + 1) begin n_bad++; $display("FAIL ill_err_cycles: got %0d want 1", err_pulses - e0); end
    n_cmp++; if (wq_data.size() != base) begin n_bad++; $display("FAIL ill_no_write: got %0d writes want 0", wq_data.size() - base); end
    n_cmp++; if (count !== c0) begin n_bad++; $display("FAIL ill_count: got %0d want %0d", count, c0); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %b want 1", cmd_ready); end
    send(3, 5'd6, 5'd7, 5'd8, 16'd0, 26'd0);
    n_cmp++;
    if (wq_data.size() != base + 1 || wq_addr[wq_addr.size()-1] !== 2'd1) begin
      n_bad++; $display("FAIL ill_ptr_kept: writes %0d last addr %0d want 1 write at addr 1",
                        wq_data.size() - base, wq_addr[wq_addr.size()-1]);
    end
  endtask

  task automatic test_full_and_stall();
    logic [32:0] r;
    logic [31:0] w5;
    int base;
    do_clear();
    base = wq_data.size();
    for (int i = 0; i < 4; i++) begin
      int m = $urandom_range(0, 15);
      logic [4:0] rs = 5'($urandom), rt = 5'($urandom), rd = 5'($urandom);
      logic [15:0] imm = 16'($urandom);
      logic [25:0] tg = 26'($urandom);
      r = ref_enc(m, rs, rt, rd, imm, tg);
      send(m, rs, rt, rd, imm, tg);
      n_cmp++;
      if (wq_data.size() != base + i + 1 || wq_data[base+i] !== r[31:0] || wq_addr[base+i] !== AW'(i)) begin
        n_bad++; $display("FAIL full_write%0d: got %0d writes, want data %h at addr %0d", i,
                          wq_data.size() - base, r[31:0], i);
      end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", full); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", count); end
    r = ref_enc(13, 5'd9, 5'd10, 5'd0, 16'hBEEF, 26'd0);
    w5 = r[31:0];
    set_fields(13, 5'd9, 5'd10, 5'd0, 16'hBEEF, 26'd0);
    cmd_valid = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    n_cmp++; if (wq_data.size() != base + 4) begin n_bad++; $display("FAIL full_stall: got %0d extra writes want 0", wq_data.size() - base - 4); end
    n_cmp++; if (count !== 3'd4 || full !== 1'b1) begin n_bad++; $display("FAIL full_hold: count %0d full %b want 4 and 1", count, full); end
    do_clear();
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (wq_data.size() != base + 5 || wq_data[base+4] !== w5 || wq_addr[base+4] !== 2'd0) begin
      n_bad++; $display("FAIL full_after_clear: got %0d writes want 5, want data %h at addr 0",
                        wq_data.size() - base, w5);
    end
    n_cmp++; if (count !== 3'd1 || full !== 1'b0) begin n_bad++; $display("FAIL full_cleared: count %0d full %b want 1 and 0", count, full); end
  endtask

  task automatic test_clear_mid();
    int base;
    do_clear();
    send(2, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0);
    base = wq_data.size();
    set_fields(1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
    cmd_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 cmd_valid = 1'b0;
    do_clear();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", count); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (wq_data.size() != base) begin n_bad++; $display("FAIL mid_no_write: got %0d writes want 0", wq_data.size() - base); end
  endtask

  task automatic test_checksum();
`ifdef INSTR_LOADER_CHECKSUM_EN
    do_clear();
    send(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    send(7, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0);
    n_cmp++; if (checksum !== 32'h202A1825) begin n_bad++; $display("FAIL checksum_two: got %h want 202a1825", checksum); end
    do_clear();
    n_cmp++; if (checksum !== 32'd0) begin n_bad++; $display("FAIL checksum_clear: got %h want 0", checksum); end
`endif
  endtask

  task automatic test_random();
    int mp = 0;
    logic [31:0] mchk = '0;
    do_clear();
    for (int it = 0; it < 40; it++) begin
      int m, base, e0;
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tg;
      logic [32:0] r;
      if (mp == 4) begin
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL rnd_full: got %b want 1", full); end
        do_clear(); mp = 0; mchk = '0;
      end
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      imm = 16'($urandom); tg = 26'($urandom);
      r = ref_enc(m, rs, rt, rd, imm, tg);
      base = wq_data.size(); e0 = err_pulses;
      send(m, rs, rt, rd, imm, tg);
      if (r[32]) begin
        n_cmp++;
        if (err_pulses != e0 + 1 || wq_data.size() != base) begin
          n_bad++; $display("FAIL rnd_illegal%0d: err cycles %0d writes %0d want 1 and 0", it,
                            err_pulses - e0, wq_data.size() - base);
        end
      end else begin
        n_cmp++;
        if (wq_data.size() != base + 1 || wq_data[base] !== r[31:0] || wq_addr[base] !== AW'(mp)) begin
          n_bad++; $display("FAIL rnd_write%0d: mnem %0d writes %0d want data %h at addr %0d", it, m,
                            wq_data.size() - base, r[31:0], mp);
        end
        mp++;
        mchk ^= r[31:0];
      end
      n_cmp++; if (count !== (AW+1)'(mp)) begin n_bad++; $display("FAIL rnd_count%0d: got %0d want %0d", it, count, mp); end
`ifdef INSTR_LOADER_CHECKSUM_EN
      n_cmp++; if (checksum !== mchk) begin n_bad++; $display("FAIL rnd_checksum%0d: got %h want %h", it, checksum, mchk); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sequence();
    test_illegal();
    test_full_and_stall();
    test_clear_mid();
    test_checksum();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
